// File: rtl/round_robin_distributor.sv
// One valid/ready input stream spread round-robin over three single-entry output slots.
// A busy slot is skipped, so one stalled consumer never blocks the other two lanes.
module round_robin_distributor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [1:0]       last_dest
);

  logic [2:0]       valid_q;
  logic [2:0]       valid_d;
  logic [WIDTH-1:0] data_q [3];
  logic [WIDTH-1:0] data_d [3];
  logic [1:0]       ptr_q;
  logic [1:0]       ptr_d;
  logic [1:0]       last_dest_q;
  logic [1:0]       last_dest_d;

  logic [2:0] out_ready;
  logic [2:0] load;
  logic [1:0] ptr_eff;
  logic [1:0] cand1;
  logic [1:0] cand2;
  logic [1:0] dest;
  logic       accept;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    logic [1:0] r;
    case (v)
      2'd0:    r = 2'd1;
      2'd1:    r = 2'd2;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  assign out_ready = {out2_ready, out1_ready, out0_ready};

  // Freedom is judged from registered valids only: a slot draining this cycle is
  // still busy, which keeps in_ready free of any path from the outN_ready inputs.
  always_comb begin
    ptr_eff  = (ptr_q == 2'd3) ? 2'd0 : ptr_q;
    cand1    = inc3(ptr_eff);
    cand2    = inc3(cand1);
    dest     = cand2;
    if (!valid_q[ptr_eff]) begin
      dest = ptr_eff;
    end else if (!valid_q[cand1]) begin
      dest = cand1;
    end
    in_ready = ~&valid_q;
    accept   = in_valid & in_ready;
  end

  always_comb begin
    ptr_d       = ptr_eff;
    last_dest_d = last_dest_q;
    if (accept) begin
      ptr_d       = inc3(dest);
      last_dest_d = dest;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_slot
      always_comb begin
        load[gi]    = accept && (dest == 2'(gi));
        valid_d[gi] = valid_q[gi] & ~out_ready[gi];
        data_d[gi]  = data_q[gi];
        if (load[gi]) begin
          valid_d[gi] = 1'b1;
          data_d[gi]  = in_data;
        end
      end

      always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
          valid_q[gi] <= 1'b0;
          data_q[gi]  <= '0;
        end else begin
          valid_q[gi] <= valid_d[gi];
          data_q[gi]  <= data_d[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      ptr_q       <= 2'd0;
      last_dest_q <= 2'd0;
    end else begin
      ptr_q       <= ptr_d;
      last_dest_q <= last_dest_d;
    end
  end

  assign out0_data  = data_q[0];
  assign out1_data  = data_q[1];
  assign out2_data  = data_q[2];
  assign out0_valid = valid_q[0];
  assign out1_valid = valid_q[1];
  assign out2_valid = valid_q[2];
  assign last_dest  = last_dest_q;

endmodule

// File: tb/tb_round_robin_distributor.sv
// Directed stimulus with per-slot expected-word queues; a negedge monitor pops and
// compares every word a consumer takes.
module tb_round_robin_distributor;

  logic       clk = 1'b0;
  logic       res_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out0_data, out1_data, out2_data;
  logic       out0_valid, out1_valid, out2_valid;
  logic       out0_ready = 1'b0, out1_ready = 1'b0, out2_ready = 1'b0;
  logic [1:0] last_dest;

  int total = 0;
  int bad = 0;

  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  logic [7:0] exp2[$];

  always #5 clk = ~clk;

  round_robin_distributor #(.WIDTH(8)) dut (
    .clk(clk), .res_n(res_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out2_data(out2_data), .out2_valid(out2_valid), .out2_ready(out2_ready),
    .last_dest(last_dest)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, got, want);
    end else begin
      $display("ok   %s: 0x%0h", name, got);
    end
  endtask

  task automatic pop_chk(input int slot, input logic [7:0] got);
    logic [7:0] want;
    int n;
    case (slot)
      0: n = exp0.size();
      1: n = exp1.size();
      default: n = exp2.size();
    endcase
    total++;
    if (n == 0) begin
      bad++;
      $display("FAIL out%0d_unexpected: got=0x%0h want=<none>", slot, got);
    end else begin
      case (slot)
        0: want = exp0.pop_front();
        1: want = exp1.pop_front();
        default: want = exp2.pop_front();
      endcase
      if (got !== want) begin
        bad++;
        $display("FAIL out%0d_word: got=0x%0h want=0x%0h", slot, got, want);
      end else begin
        $display("ok   out%0d_word: 0x%0h", slot, got);
      end
    end
  endtask

  // Handshake values are stable at negedge; the transfer completes at the next posedge.
  always @(negedge clk) begin
    if (res_n) begin
      if (out0_valid && out0_ready) pop_chk(0, out0_data);
      if (out1_valid && out1_ready) pop_chk(1, out1_data);
      if (out2_valid && out2_ready) pop_chk(2, out2_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input logic r0, input logic r1, input logic r2);
    out0_ready = r0;
    out1_ready = r1;
    out2_ready = r2;
  endtask

  task automatic send(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    set_ready(1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 res_n = 1'b0;
    #1;
    exp0.delete();
    exp1.delete();
    exp2.delete();
    @(negedge clk);
    res_n = 1'b1;
    tick();
  endtask

  task automatic drain_all();
    set_ready(1'b1, 1'b1, 1'b1);
    repeat (3) tick();
    set_ready(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Test 1: state while reset is held
    #12;
    chk("rst_valid", {29'd0, out2_valid, out1_valid, out0_valid}, 32'd0);
    chk("rst_data0", out0_data, 32'h00);
    chk("rst_data1", out1_data, 32'h00);
    chk("rst_data2", out2_data, 32'h00);
    chk("rst_last_dest", last_dest, 32'd0);
    chk("rst_in_ready", in_ready, 32'd1);
    @(negedge clk);
    res_n = 1'b1;
    tick();

    // Test 2: all consumers ready, back-to-back words rotate 0,1,2,0
    set_ready(1'b1, 1'b1, 1'b1);
    exp0.push_back(8'h11); exp1.push_back(8'h22); exp2.push_back(8'h33); exp0.push_back(8'h44);
    chk("t2_in_ready_a", in_ready, 32'd1);
    send(8'h11); chk("t2_last_dest_a", last_dest, 32'd0);
    chk("t2_in_ready_b", in_ready, 32'd1);
    send(8'h22); chk("t2_last_dest_b", last_dest, 32'd1);
    chk("t2_in_ready_c", in_ready, 32'd1);
    send(8'h33); chk("t2_last_dest_c", last_dest, 32'd2);
    chk("t2_in_ready_d", in_ready, 32'd1);
    send(8'h44); chk("t2_last_dest_d", last_dest, 32'd0);
    drain_all();

    // Test 3: consumer 1 stalled, slot 1 held stable and skipped
    do_reset();
    set_ready(1'b1, 1'b0, 1'b1);
    exp0.push_back(8'hA1); exp1.push_back(8'hA2); exp2.push_back(8'hA3); exp0.push_back(8'hA4);
    send(8'hA1); chk("t3_last_dest_a", last_dest, 32'd0);
    send(8'hA2); chk("t3_last_dest_b", last_dest, 32'd1);
    send(8'hA3); chk("t3_last_dest_c", last_dest, 32'd2);
    chk("t3_out1_hold_a", out1_data, 32'hA2);
    send(8'hA4); chk("t3_last_dest_d", last_dest, 32'd0);
    tick();
    chk("t3_out1_valid", out1_valid, 32'd1);
    chk("t3_out1_hold_b", out1_data, 32'hA2);
    drain_all();

    // Test 4: all stalled -> full after three, one-cycle drain of slot 2 admits the 4th
    do_reset();
    exp0.push_back(8'hB1); exp1.push_back(8'hB2); exp2.push_back(8'hB3); exp2.push_back(8'hB4);
    send(8'hB1); send(8'hB2); send(8'hB3);
    in_data = 8'hB4; in_valid = 1'b1;
    chk("t4_full_in_ready", in_ready, 32'd0);
    tick();
    chk("t4_full_last_dest", last_dest, 32'd2);
    chk("t4_full_out2_data", out2_data, 32'hB3);
    out2_ready = 1'b1;
    chk("t4_drain_in_ready", in_ready, 32'd0);
    tick();
    out2_ready = 1'b0;
    chk("t4_after_in_ready", in_ready, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("t4_b4_dest", last_dest, 32'd2);
    chk("t4_b4_data", out2_data, 32'hB4);
    chk("t4_full_again", in_ready, 32'd0);
    drain_all();

    // Test 5: slot 0 draining with ptr=0 -> new word goes to slot 1
    do_reset();
    exp0.push_back(8'hC1); exp1.push_back(8'hC2); exp2.push_back(8'hC3); exp1.push_back(8'hC4);
    send(8'hC1); send(8'hC2); send(8'hC3);
    set_ready(1'b0, 1'b1, 1'b1);
    tick();
    set_ready(1'b1, 1'b0, 1'b0);
    send(8'hC4);
    out0_ready = 1'b0;
    chk("t5_dest", last_dest, 32'd1);
    chk("t5_out1_data", out1_data, 32'hC4);
    chk("t5_out0_valid", out0_valid, 32'd0);
    chk("t5_out0_data_kept", out0_data, 32'hC1);
    drain_all();

    // Test 6: asynchronous reset mid-stream discards held words
    do_reset();
    exp0.push_back(8'hD1); exp1.push_back(8'hD2);
    send(8'hD1); send(8'hD2);
    chk("t6_two_valid", {29'd0, out2_valid, out1_valid, out0_valid}, 32'd3);
    #2 res_n = 1'b0;
    #1;
    chk("t6_async_valid", {29'd0, out2_valid, out1_valid, out0_valid}, 32'd0);
    chk("t6_async_data0", out0_data, 32'h00);
    chk("t6_async_last_dest", last_dest, 32'd0);
    exp0.delete(); exp1.delete(); exp2.delete();
    @(negedge clk);
    res_n = 1'b1;
    tick();
    exp0.push_back(8'hD3);
    send(8'hD3);
    chk("t6_post_dest", last_dest, 32'd0);
    chk("t6_post_data", out0_data, 32'hD3);
    drain_all();

    repeat (2) tick();
    chk("final_pending", exp0.size() + exp1.size() + exp2.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
